// File: rtl/movimenta_tiros_pkg.sv
// Shared definitions for the shot-movement block: record layout, direction
// encoding, controller state codes and playfield size.
package movimenta_tiros_pkg;

    // Shot record layout: [11] valid, [10:8] dir, [7:4] x, [3:0] y
    localparam int REC_W     = 12;
    localparam int BIT_VALID = 11;
    localparam int DIR_MSB   = 10;
    localparam int DIR_LSB   = 8;
    localparam int X_MSB     = 7;
    localparam int X_LSB     = 4;
    localparam int Y_MSB     = 3;
    localparam int Y_LSB     = 0;

    // Square playfield, 16 cells per axis; y grows downward
    localparam int         FIELD_SIZE = 16;
    localparam logic [3:0] COORD_MAX  = 4'(FIELD_SIZE - 1);
    localparam logic [3:0] COORD_MIN  = 4'd0;

    // Direction encoding, clockwise starting at north
    typedef enum logic [2:0] {
        DIR_N  = 3'd0,
        DIR_NE = 3'd1,
        DIR_E  = 3'd2,
        DIR_SE = 3'd3,
        DIR_S  = 3'd4,
        DIR_SW = 3'd5,
        DIR_W  = 3'd6,
        DIR_NW = 3'd7
    } dir_t;

    // Controller states; the code is also what the debug port shows
    typedef enum logic [3:0] {
        ST_INICIO  = 4'd0,
        ST_ESPERA  = 4'd1,
        ST_LE      = 4'd2,
        ST_AGUARDA = 4'd3,
        ST_CALCULA = 4'd4,
        ST_ESCREVE = 4'd5,
        ST_PROXIMO = 4'd6,
        ST_FIM     = 4'd7
    } estado_t;

    // Debug code reported for any state register value outside the table
    localparam logic [3:0] DB_ILEGAL = 4'hF;

    // Step codes for one axis: 2'b01 = +1, 2'b11 = -1, 2'b00 = stay
    localparam logic [1:0] PASSO_MAIS  = 2'b01;
    localparam logic [1:0] PASSO_MENOS = 2'b11;
    localparam logic [1:0] PASSO_ZERO  = 2'b00;

    // Horizontal step implied by a direction
    function automatic logic [1:0] delta_x(input dir_t d);
        logic [1:0] r;
        case (d)
            DIR_NE, DIR_E, DIR_SE: r = PASSO_MAIS;
            DIR_SW, DIR_W, DIR_NW: r = PASSO_MENOS;
            default:               r = PASSO_ZERO;
        endcase
        return r;
    endfunction

    // Vertical step implied by a direction (north decreases y)
    function automatic logic [1:0] delta_y(input dir_t d);
        logic [1:0] r;
        case (d)
            DIR_N, DIR_NE, DIR_NW: r = PASSO_MENOS;
            DIR_SE, DIR_S, DIR_SW: r = PASSO_MAIS;
            default:               r = PASSO_ZERO;
        endcase
        return r;
    endfunction

    // Sign-extend a step code so it can be added with 4-bit wraparound
    function automatic logic [3:0] passo_4b(input logic [1:0] p);
        return {p[1], p[1], p};
    endfunction

    // True when applying step p to coordinate c would leave the field
    function automatic logic sai_do_campo(input logic [3:0] c, input logic [1:0] p);
        logic r;
        if (p == PASSO_MAIS) begin
            r = (c == COORD_MAX);
        end else if (p == PASSO_MENOS) begin
            r = (c == COORD_MIN);
        end else begin
            r = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/movimenta_tiros_calcula_posicao_tiro.sv
// Combinational next-position unit: advances one shot record a single cell
// along its direction, or invalidates it in place if it would leave the field.
module calcula_posicao_tiro
    import movimenta_tiros_pkg::*;
(
    input  logic [REC_W-1:0] i_tiro,
    output logic [REC_W-1:0] o_tiro
);

    logic       w_valido;
    dir_t       w_dir;
    logic [3:0] w_x;
    logic [3:0] w_y;
    logic [1:0] w_dx;
    logic [1:0] w_dy;
    logic [3:0] w_nx;
    logic [3:0] w_ny;
    logic       w_fora;

    // Unpack the record and work out the candidate position and bounds
    always_comb begin
        w_valido = i_tiro[BIT_VALID];
        w_dir    = dir_t'(i_tiro[DIR_MSB:DIR_LSB]);
        w_x      = i_tiro[X_MSB:X_LSB];
        w_y      = i_tiro[Y_MSB:Y_LSB];
        w_dx     = delta_x(w_dir);
        w_dy     = delta_y(w_dir);
        w_nx     = w_x + passo_4b(w_dx);
        w_ny     = w_y + passo_4b(w_dy);
        w_fora   = sai_do_campo(w_x, w_dx) | sai_do_campo(w_y, w_dy);
    end

    // Build the updated record; an escaping shot keeps position and dir
    always_comb begin
        o_tiro = i_tiro;
        if (!w_valido) begin
            o_tiro = i_tiro;
        end else if (w_fora) begin
            o_tiro[BIT_VALID] = 1'b0;
        end else begin
            o_tiro[X_MSB:X_LSB] = w_nx;
            o_tiro[Y_MSB:Y_LSB] = w_ny;
        end
    end

endmodule

// File: rtl/movimenta_tiros.sv
// Shot-movement controller: on a start pulse walks every slot of the shot
// table, reads each record, advances valid shots one cell and writes them
// back, then reports the surviving shot count with a one-cycle done pulse.
module movimenta_tiros
    import movimenta_tiros_pkg::*;
#(
    parameter int N_TIROS = 16
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic             movimenta_tiro,
    output logic             fim_move_tiros,
    output logic [3:0]       mem_addr,
    output logic             mem_rd,
    input  logic [REC_W-1:0] mem_rdata,
    output logic             mem_wr,
    output logic [REC_W-1:0] mem_wdata,
    output logic [4:0]       tiros_ativos,
    output logic [3:0]       db_estado
);

    localparam logic [3:0] ULTIMO = 4'(N_TIROS - 1);

    estado_t          r_estado;
    estado_t          w_prox;
    logic [3:0]       r_indice;
    logic [4:0]       r_ativos;
    logic [REC_W-1:0] r_registro;
    logic [REC_W-1:0] w_atualizado;

    calcula_posicao_tiro u_calcula (
        .i_tiro (r_registro),
        .o_tiro (w_atualizado)
    );

    // The table address always follows the current slot index
    assign mem_addr = r_indice;

    // Next-state selection; unknown codes recover through inicio
    always_comb begin
        w_prox = ST_INICIO;
        case (r_estado)
            ST_INICIO:  w_prox = ST_ESPERA;
            ST_ESPERA: begin
                if (movimenta_tiro) begin
                    w_prox = ST_LE;
                end else begin
                    w_prox = ST_ESPERA;
                end
            end
            ST_LE:      w_prox = ST_AGUARDA;
            ST_AGUARDA: w_prox = ST_CALCULA;
            ST_CALCULA: begin
                if (r_registro[BIT_VALID]) begin
                    w_prox = ST_ESCREVE;
                end else begin
                    w_prox = ST_PROXIMO;
                end
            end
            ST_ESCREVE: w_prox = ST_PROXIMO;
            ST_PROXIMO: begin
                if (r_indice == ULTIMO) begin
                    w_prox = ST_FIM;
                end else begin
                    w_prox = ST_LE;
                end
            end
            ST_FIM:     w_prox = ST_ESPERA;
            default:    w_prox = ST_INICIO;
        endcase
    end

    // Debug view of the state register, flagging corrupted codes
    always_comb begin
        db_estado = DB_ILEGAL;
        case (r_estado)
            ST_INICIO:  db_estado = 4'd0;
            ST_ESPERA:  db_estado = 4'd1;
            ST_LE:      db_estado = 4'd2;
            ST_AGUARDA: db_estado = 4'd3;
            ST_CALCULA: db_estado = 4'd4;
            ST_ESCREVE: db_estado = 4'd5;
            ST_PROXIMO: db_estado = 4'd6;
            ST_FIM:     db_estado = 4'd7;
            default:    db_estado = DB_ILEGAL;
        endcase
    end

    // State, datapath and Moore outputs; outputs are registered from the
    // next state so they line up exactly with the state they belong to
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado       <= ST_INICIO;
            r_indice       <= 4'd0;
            r_ativos       <= 5'd0;
            r_registro     <= {REC_W{1'b0}};
            tiros_ativos   <= 5'd0;
            mem_rd         <= 1'b0;
            mem_wr         <= 1'b0;
            mem_wdata      <= {REC_W{1'b0}};
            fim_move_tiros <= 1'b0;
        end else begin
            r_estado       <= w_prox;
            mem_rd         <= (w_prox == ST_LE);
            mem_wr         <= (w_prox == ST_ESCREVE);
            fim_move_tiros <= (w_prox == ST_FIM);

            // Write data is only ever non-zero while the write strobe is up
            if (w_prox == ST_ESCREVE) begin
                mem_wdata <= w_atualizado;
            end else begin
                mem_wdata <= {REC_W{1'b0}};
            end

            case (r_estado)
                ST_ESPERA: begin
                    if (movimenta_tiro) begin
                        r_indice <= 4'd0;
                        r_ativos <= 5'd0;
                    end
                end
                ST_AGUARDA: r_registro <= mem_rdata;
                ST_CALCULA: begin
                    if (w_atualizado[BIT_VALID]) begin
                        r_ativos <= r_ativos + 5'd1;
                    end
                end
                ST_PROXIMO: begin
                    if (r_indice != ULTIMO) begin
                        r_indice <= r_indice + 4'd1;
                    end
                end
                default: ;
            endcase

            // Publish the count only when a pass actually completes
            if ((w_prox == ST_FIM) && (r_estado != ST_FIM)) begin
                tiros_ativos <= r_ativos;
            end
        end
    end

endmodule

// File: tb/tb_movimenta_tiros.sv
// Bench for movimenta_tiros: a shot-table memory model, a behavioural model
// of one pass (expected writes, survivors, done cycle), a per-cycle compare
// process and directed plus randomized passes.
module tb_movimenta_tiros;

    logic        clock = 1'b0;
    logic        reset;
    logic        movimenta_tiro;
    logic        fim_move_tiros;
    logic [3:0]  mem_addr;
    logic        mem_rd;
    logic [11:0] mem_rdata;
    logic        mem_wr;
    logic [11:0] mem_wdata;
    logic [4:0]  tiros_ativos;
    logic [3:0]  db_estado;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    movimenta_tiros #(.N_TIROS(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .movimenta_tiro (movimenta_tiro),
        .fim_move_tiros (fim_move_tiros),
        .mem_addr       (mem_addr),
        .mem_rd         (mem_rd),
        .mem_rdata      (mem_rdata),
        .mem_wr         (mem_wr),
        .mem_wdata      (mem_wdata),
        .tiros_ativos   (tiros_ativos),
        .db_estado      (db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // ---------------- shot-table memory ----------------
    logic [11:0] mem [16];
    logic        rd_pend = 1'b0;
    logic [3:0]  rd_addr = 4'd0;

    always @(negedge clock) begin
        rd_pend = mem_rd;
        rd_addr = mem_addr;
        if (mem_wr === 1'b1) mem[mem_addr] = mem_wdata;
    end

    // Read data appears the cycle after the strobe; garbage otherwise
    always @(posedge clock) begin
        #1;
        if (rd_pend) mem_rdata = mem[rd_addr];
        else         mem_rdata = 12'($urandom);
    end

    // ---------------- behavioural model ----------------
    typedef struct { logic [3:0] a; logic [11:0] d; } wr_t;
    wr_t         exp_wr_q [$];
    logic [11:0] exp_mem [16];
    int          exp_fim_rel;
    int          exp_cnt;
    int          exp_tiros = 0;
    bit          active = 0;
    bit          done = 0;
    int          c0 = 0;
    int          fim_rel = -1;
    int          next_rd = 0;

    function automatic logic [11:0] move_ref(input logic [11:0] r);
        int d, x, y, nx, ny;
        d = int'(r[10:8]); x = int'(r[7:4]); y = int'(r[3:0]);
        nx = x; ny = y;
        if (d == 1 || d == 2 || d == 3) nx = x + 1;
        if (d == 5 || d == 6 || d == 7) nx = x - 1;
        if (d == 0 || d == 1 || d == 7) ny = y - 1;
        if (d == 3 || d == 4 || d == 5) ny = y + 1;
        if (nx < 0 || nx > 15 || ny < 0 || ny > 15) return {1'b0, r[10:0]};
        return {1'b1, r[10:8], 4'(nx), 4'(ny)};
    endfunction

    task automatic build_model();
        int k;
        logic [11:0] u;
        wr_t w;
        exp_wr_q.delete();
        k = 0; exp_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            exp_mem[i] = mem[i];
            if (mem[i][11]) begin
                k++;
                u = move_ref(mem[i]);
                w.a = 4'(i); w.d = u;
                exp_wr_q.push_back(w);
                exp_mem[i] = u;
                if (u[11]) exp_cnt++;
            end
        end
        exp_fim_rel = 1 + 4 * 16 + k;
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        wr_t e;
        if (reset === 1'b0) begin
            if (active) begin
                if (mem_rd) begin
                    chk("rd_addr", mem_addr, next_rd);
                    next_rd++;
                end
                if (mem_wr) begin
                    if (exp_wr_q.size() == 0) begin
                        chk("unexpected_wr", 1, 0);
                    end else begin
                        e = exp_wr_q.pop_front();
                        chk("wr_addr", mem_addr, e.a);
                        chk("wr_data", mem_wdata, e.d);
                    end
                end else begin
                    chk("wdata_idle", mem_wdata, 0);
                end
                if (fim_move_tiros) begin
                    fim_rel = cyc - c0;
                    chk("fim_cycle", fim_rel, exp_fim_rel);
                    chk("tiros_at_fim", tiros_ativos, exp_cnt);
                    chk("writes_left", exp_wr_q.size(), 0);
                    chk("reads_done", next_rd, 16);
                    exp_tiros = exp_cnt;
                    active = 0;
                    done = 1;
                end else begin
                    chk("tiros_hold", tiros_ativos, exp_tiros);
                end
            end else begin
                chk("no_fim_idle", fim_move_tiros, 0);
                chk("no_wr_idle", mem_wr, 0);
                chk("tiros_idle", tiros_ativos, exp_tiros);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 12'h000;
    endtask

    task automatic start_pass();
        build_model();
        @(negedge clock);
        chk("idle_state", db_estado, 1);
        fim_rel = -1;
        done = 0;
        next_rd = 0;
        c0 = cyc;
        active = 1;
        movimenta_tiro = 1'b1;
        @(negedge clock);
        movimenta_tiro = 1'b0;
    endtask

    task automatic run_pass(input bit extra);
        int n;
        start_pass();
        n = 0;
        while (!done && n < 400) begin
            @(negedge clock);
            n++;
            movimenta_tiro = (extra && n == 10) ? 1'b1 : 1'b0;
        end
        movimenta_tiro = 1'b0;
        if (!done) begin
            chk("fim_timeout", 0, 1);
            active = 0;
        end
        @(negedge clock);
        for (int i = 0; i < 16; i++) chk("mem_slot", mem[i], exp_mem[i]);
    endtask

    logic [11:0] oito [8];
    logic [11:0] r;
    int          n;
    int          c;
    logic [3:0]  v;

    initial begin
        reset = 1'b1;
        movimenta_tiro = 1'b0;
        clear_mem();
        repeat (3) @(negedge clock);
        chk("rst_estado", db_estado, 0);
        chk("rst_fim", fim_move_tiros, 0);
        chk("rst_rd", mem_rd, 0);
        chk("rst_wr", mem_wr, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_tiros", tiros_ativos, 0);
        reset = 1'b0;
        @(negedge clock);

        // All slots invalid
        clear_mem();
        run_pass(1'b0);
        chk("empty_fim_rel", fim_rel, 65);
        chk("empty_tiros", tiros_ativos, 0);

        // Single shot moving east
        clear_mem();
        mem[3] = 12'hA57;
        run_pass(1'b0);
        chk("east_fim_rel", fim_rel, 66);
        chk("east_rec", mem[3], 12'hA67);
        chk("east_tiros", tiros_ativos, 1);

        // Two shots leaving the field
        clear_mem();
        mem[0]  = 12'hE04;
        mem[15] = 12'hBFF;
        run_pass(1'b0);
        chk("edge_fim_rel", fim_rel, 67);
        chk("edge_w_rec", mem[0], 12'h604);
        chk("edge_se_rec", mem[15], 12'h3FF);
        chk("edge_tiros", tiros_ativos, 0);

        // Eight directions from the centre, with a stray start mid-pass
        clear_mem();
        for (int d = 0; d < 8; d++) mem[d] = {1'b1, 3'(d), 4'd8, 4'd8};
        oito[0] = 12'h887; oito[1] = 12'h997; oito[2] = 12'hA98; oito[3] = 12'hB99;
        oito[4] = 12'hC89; oito[5] = 12'hD79; oito[6] = 12'hE78; oito[7] = 12'hF77;
        run_pass(1'b1);
        for (int d = 0; d < 8; d++) chk("dir_rec", mem[d], oito[d]);
        chk("dir_tiros", tiros_ativos, 8);
        chk("dir_fim_rel", fim_rel, 73);
        @(negedge clock);
        chk("single_fim", db_estado, 1);

        // Reset while writing: abort, no done pulse, count cleared
        clear_mem();
        mem[2] = 12'hA57;
        start_pass();
        n = 0;
        while (db_estado != 4'd5 && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("reach_escreve", db_estado, 5);
        chk("wr_before_rst", mem_wr, 1);
        #1;
        reset = 1'b1;
        active = 0;
        exp_tiros = 0;
        exp_wr_q.delete();
        #1;
        chk("rst_mid_wr", mem_wr, 0);
        chk("rst_mid_estado", db_estado, 0);
        chk("rst_mid_fim", fim_move_tiros, 0);
        chk("rst_mid_tiros", tiros_ativos, 0);
        chk("rst_mid_wdata", mem_wdata, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("after_rst_estado", db_estado, 1);

        // Randomized tables, half of them crowded against the borders
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 16; i++) begin
                r = 12'($urandom);
                if (p[0]) begin
                    c = $urandom_range(0, 3);
                    v = (c == 0) ? 4'd0 : (c == 1) ? 4'd1 : (c == 2) ? 4'd14 : 4'd15;
                    r[7:4] = v;
                    c = $urandom_range(0, 3);
                    v = (c == 0) ? 4'd0 : (c == 1) ? 4'd1 : (c == 2) ? 4'd14 : 4'd15;
                    r[3:0] = v;
                end
                mem[i] = r;
            end
            run_pass(1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
